// File: rtl/mips_pkg.sv
// Shared address map, FSM state and region encodings for the MIPS memory subsystem.
package mips_pkg;

    localparam logic [31:0] TEXT_BASE_DEF = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE_DEF = 32'h1001_0000;
    localparam logic [31:0] GPIO_ADDR     = 32'hFFFF_0000;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_state_t;

    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_GPIO, REG_NONE} region_t;

endpackage

// File: rtl/mips_addr_decode.sv
// Combinational address decode: region select, word index and error flag.
// The GPIO register exists only when MIPS_MEM_CTRL_GPIO_EN is defined.
module mips_addr_decode
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] TEXT_BASE  = ADDR_WIDTH'(TEXT_BASE_DEF),
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE  = ADDR_WIDTH'(DATA_BASE_DEF),
    parameter int                    ROM_DEPTH  = 64,
    parameter int                    RAM_DEPTH  = 64,
    parameter int                    IDX_W      = 6
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output region_t               region,
    output logic [IDX_W-1:0]      word_idx,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] ROM_BYTES = ADDR_WIDTH'(4 * ROM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RAM_BYTES = ADDR_WIDTH'(4 * RAM_DEPTH);

    logic [ADDR_WIDTH-1:0] rom_off;
    logic [ADDR_WIDTH-1:0] ram_off;

    // base <= addr < base+size collapses to one unsigned compare on the wrapped offset
    always_comb begin
        rom_off  = addr - TEXT_BASE;
        ram_off  = addr - DATA_BASE;
        region   = REG_NONE;
        word_idx = '0;
        if (rom_off < ROM_BYTES) begin
            region   = REG_ROM;
            word_idx = rom_off[IDX_W+1:2];
        end else if (ram_off < RAM_BYTES) begin
            region   = REG_RAM;
            word_idx = ram_off[IDX_W+1:2];
        end
`ifdef MIPS_MEM_CTRL_GPIO_EN
        else if (addr == ADDR_WIDTH'(GPIO_ADDR)) begin
            region = REG_GPIO;
        end
`endif
        err = (addr[1:0] != 2'b00) || (region == REG_NONE) || (region == REG_ROM && we);
    end

endmodule

// File: rtl/mips_mem_ctrl.sv
// Memory controller for the multicycle MIPS core: one request at a time, ROM/RAM
// decode, WAIT_CYCLES access cycles, one-cycle response. MIPS_MEM_CTRL_GPIO_EN adds gpio_out.
module mips_mem_ctrl
    import mips_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] TEXT_BASE   = ADDR_WIDTH'(TEXT_BASE_DEF),
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE   = ADDR_WIDTH'(DATA_BASE_DEF),
    parameter int                    ROM_DEPTH   = 64,
    parameter int                    RAM_DEPTH   = 64,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic                         req_we,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [DATA_WIDTH-1:0]        req_wdata,
    output logic                         req_ready,
    output logic                         rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
`ifdef MIPS_MEM_CTRL_GPIO_EN
    output logic [DATA_WIDTH-1:0]        gpio_out,
`endif
    output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]        rom_rdata,
    output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
    output logic                         ram_we,
    output logic [DATA_WIDTH-1:0]        ram_wdata,
    input  logic [DATA_WIDTH-1:0]        ram_rdata
);

    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int IDX_W  = (ROM_AW > RAM_AW) ? ROM_AW : RAM_AW;
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    mem_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    region_t               region_q, region_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] sel_rdata;

    region_t               dec_region;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_err;

`ifdef MIPS_MEM_CTRL_GPIO_EN
    logic [DATA_WIDTH-1:0] gpio_q, gpio_d;
`endif

    mips_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .TEXT_BASE  (TEXT_BASE),
        .DATA_BASE  (DATA_BASE),
        .ROM_DEPTH  (ROM_DEPTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr     (req_addr),
        .we       (req_we),
        .region   (dec_region),
        .word_idx (dec_idx),
        .err      (dec_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            region_q <= REG_NONE;
            idx_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef MIPS_MEM_CTRL_GPIO_EN
            gpio_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            region_q <= region_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef MIPS_MEM_CTRL_GPIO_EN
            gpio_q   <= gpio_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = dec_err ? RESP : ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (region_q)
            REG_ROM:  sel_rdata = rom_rdata;
            REG_RAM:  sel_rdata = ram_rdata;
`ifdef MIPS_MEM_CTRL_GPIO_EN
            REG_GPIO: sel_rdata = gpio_q;
`endif
            default:  sel_rdata = '0;
        endcase
    end

    // Request latch, wait counter and response capture
    always_comb begin
        cnt_d    = cnt_q;
        we_d     = we_q;
        region_d = region_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (state_q == IDLE && req_valid) begin
            we_d     = req_we;
            region_d = dec_region;
            idx_d    = dec_idx;
            wdata_d  = req_wdata;
            cnt_d    = CNT_INIT;
            if (dec_err) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end
        end else if (state_q == ACCESS) begin
            if (cnt_q == '0) begin
                rdata_d = we_q ? '0 : sel_rdata;
                err_d   = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

`ifdef MIPS_MEM_CTRL_GPIO_EN
    // The register takes the store data on the edge that leaves RESP
    always_comb begin
        gpio_d = gpio_q;
        if (state_q == RESP && region_q == REG_GPIO && we_q && !err_q) gpio_d = wdata_q;
    end
    assign gpio_out = gpio_q;
`endif

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        ram_we    = (state_q == ACCESS) && (cnt_q == CNT_INIT) && we_q && (region_q == REG_RAM);
        rom_addr  = idx_q[ROM_AW-1:0];
        ram_addr  = idx_q[RAM_AW-1:0];
        ram_wdata = wdata_q;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Self-checking bench for mips_mem_ctrl: timestamp-based reference model plus directed cases.
module tb_mips_mem_ctrl;

    localparam int          DEPTH   = 64;
    localparam int          W       = 1;
    localparam logic [31:0] TB_TEXT = 32'h0040_0000;
    localparam logic [31:0] TB_DATA = 32'h1001_0000;
    localparam logic [31:0] TB_GPIO = 32'hFFFF_0000;
    localparam logic [1:0]  K_ROM = 2'd0, K_RAM = 2'd1, K_GPIO = 2'd2, K_NONE = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_we, req_ready, rsp_valid, rsp_err, ram_we;
    logic [31:0] req_addr, req_wdata, rsp_rdata, rom_rdata, ram_rdata, ram_wdata;
    logic [5:0]  rom_addr, ram_addr;
    logic        r3_reset, r3_req_valid, r3_req_we, r3_req_ready, r3_rsp_valid, r3_rsp_err, r3_ram_we;
    logic [31:0] r3_req_addr, r3_req_wdata, r3_rsp_rdata, r3_rom_rdata, r3_ram_rdata, r3_ram_wdata;
    logic [5:0]  r3_rom_addr, r3_ram_addr;
`ifdef MIPS_MEM_CTRL_GPIO_EN
    logic [31:0] gpio_out, r3_gpio_out;
`endif

    mips_mem_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
`ifdef MIPS_MEM_CTRL_GPIO_EN
        .gpio_out(gpio_out),
`endif
        .rom_addr(rom_addr), .rom_rdata(rom_rdata), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mips_mem_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(r3_reset), .req_valid(r3_req_valid), .req_we(r3_req_we),
        .req_addr(r3_req_addr), .req_wdata(r3_req_wdata), .req_ready(r3_req_ready),
        .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rsp_rdata), .rsp_err(r3_rsp_err),
`ifdef MIPS_MEM_CTRL_GPIO_EN
        .gpio_out(r3_gpio_out),
`endif
        .rom_addr(r3_rom_addr), .rom_rdata(r3_rom_rdata), .ram_addr(r3_ram_addr),
        .ram_we(r3_ram_we), .ram_wdata(r3_ram_wdata), .ram_rdata(r3_ram_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory environment
    function automatic logic [31:0] rom_word(input int i);
        return (i == 0) ? 32'h2108_0003 : 32'h8C00_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    logic [31:0] ram_mem  [DEPTH];
    logic [31:0] ram3_mem [DEPTH];
    assign rom_rdata    = rom_word(int'(rom_addr));
    assign ram_rdata    = ram_mem[ram_addr];
    assign r3_rom_rdata = rom_word(int'(r3_rom_addr));
    assign r3_ram_rdata = ram3_mem[r3_ram_addr];
    always @(posedge clk) if (ram_we)    ram_mem[ram_addr]     <= ram_wdata;
    always @(posedge clk) if (r3_ram_we) ram3_mem[r3_ram_addr] <= r3_ram_wdata;

    // Reference decode straight from the address map, in wide arithmetic
    typedef struct packed { logic [1:0] kind; logic [31:0] idx; logic err; } dec_t;

    function automatic dec_t ref_dec(input logic we, input logic [31:0] a);
        dec_t d;
        longint ua = longint'({32'b0, a});
        d.kind = K_NONE;
        d.idx  = 0;
        if (ua >= longint'({32'b0, TB_TEXT}) && ua < longint'({32'b0, TB_TEXT}) + 4 * DEPTH) begin
            d.kind = K_ROM;
            d.idx  = (a - TB_TEXT) / 4;
        end else if (ua >= longint'({32'b0, TB_DATA}) && ua < longint'({32'b0, TB_DATA}) + 4 * DEPTH) begin
            d.kind = K_RAM;
            d.idx  = (a - TB_DATA) / 4;
        end
`ifdef MIPS_MEM_CTRL_GPIO_EN
        else if (a == TB_GPIO) d.kind = K_GPIO;
`endif
        d.err = (a % 4 != 0) || (d.kind == K_NONE) || (d.kind == K_ROM && we);
        return d;
    endfunction

    // Model: each accepted request is turned into cycle timestamps for its events
    int          cyc = 0;
    bit          pend = 1'b0;
    int          acc_c = -100, resp_c = -100, we_c = -100, gpio_at = 0;
    dec_t        m_d, cur_d;
    logic        m_we;
    logic [31:0] m_wdata, m_rdata;
    logic [31:0] ref_ram [DEPTH];
    logic [31:0] ref_gpio = 0, gpio_new = 0, gpio_prev = 0;

    always_comb cur_d = ref_dec(req_we, req_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            pend      <= 1'b0;
            ref_gpio  <= '0;
            gpio_new  <= '0;
            gpio_prev <= '0;
            gpio_at   <= 0;
        end else if ((!pend || cyc > resp_c) && req_valid) begin
            pend    <= 1'b1;
            acc_c   <= cyc;
            m_d     <= cur_d;
            m_we    <= req_we;
            m_wdata <= req_wdata;
            resp_c  <= cyc + (cur_d.err ? 1 : W + 1);
            we_c    <= (!cur_d.err && req_we && cur_d.kind == K_RAM) ? cyc + 1 : -100;
            if (cur_d.err || req_we) m_rdata <= '0;
            else if (cur_d.kind == K_ROM) m_rdata <= rom_word(int'(cur_d.idx));
            else if (cur_d.kind == K_RAM) m_rdata <= ref_ram[cur_d.idx[5:0]];
            else m_rdata <= ref_gpio;
            if (!cur_d.err && req_we && cur_d.kind == K_RAM) ref_ram[cur_d.idx[5:0]] <= req_wdata;
            if (!cur_d.err && req_we && cur_d.kind == K_GPIO) begin
                ref_gpio  <= req_wdata;
                gpio_prev <= (cyc >= gpio_at) ? gpio_new : gpio_prev;
                gpio_new  <= req_wdata;
                gpio_at   <= cyc + W + 2;
            end
        end
    end

    // Compare process
    bit          chk_en = 1'b0;
    int          we_cnt = 0, obs_cyc = 0;
    logic [31:0] obs_rdata = 0, last_we_data = 0;
    logic        obs_err = 0;
    logic [5:0]  last_we_addr = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, !(pend && cyc <= resp_c));
            chk("rsp_valid", rsp_valid, pend && cyc == resp_c);
            chk("ram_we", ram_we, pend && cyc == we_c);
            if (pend && cyc == resp_c) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", rsp_err, m_d.err);
            end
            if (pend && cyc == we_c) begin
                chk("ram_addr_wr", ram_addr, m_d.idx[5:0]);
                chk("ram_wdata", ram_wdata, m_wdata);
            end
            if (pend && !m_d.err && cyc > acc_c && cyc < resp_c) begin
                if (m_d.kind == K_ROM) chk("rom_addr", rom_addr, m_d.idx[5:0]);
                if (m_d.kind == K_RAM) chk("ram_addr", ram_addr, m_d.idx[5:0]);
            end
`ifdef MIPS_MEM_CTRL_GPIO_EN
            chk("gpio_out", gpio_out, (cyc >= gpio_at) ? gpio_new : gpio_prev);
`endif
            if (rsp_valid) begin
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
                obs_cyc   = cyc;
            end
            if (ram_we) begin
                we_cnt++;
                last_we_addr = ram_addr;
                last_we_data = ram_wdata;
            end
        end
    end

    // Called at a negedge; returns at the first negedge after the response cycle
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        int a;
        while (pend && cyc <= resp_c && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        a = cyc;
        @(negedge clk);
        n = 0;
        while (cyc <= resp_c && n < 50) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        chk("req_bounded", 32'(n < 50), 32'd1);
        rd  = obs_rdata;
        er  = obs_err;
        lat = obs_cyc - a;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    logic [31:0] rd, a;
    logic        er;
    int          lat, wc0, n, w3, v3;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i]  = '0;
            ram3_mem[i] = '0;
            ref_ram[i]  = '0;
        end
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        r3_reset = 1'b1; r3_req_valid = 1'b0; r3_req_we = 1'b0; r3_req_addr = '0; r3_req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
`ifdef MIPS_MEM_CTRL_GPIO_EN
        chk("rst_gpio", gpio_out, 0);
`endif
        reset = 1'b0;
        r3_reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Hand-computed expectations
        do_req(1'b0, 32'h0040_0000, 32'h0, rd, er, lat);
        chk("rom0_data", rd, 32'h2108_0003);
        chk("rom0_err", er, 0);
        chk("rom0_lat", lat, 2);

        wc0 = we_cnt;
        do_req(1'b1, 32'h1001_0000, 32'h2C, rd, er, lat);
        chk("st0_pulses", we_cnt - wc0, 1);
        chk("st0_addr", last_we_addr, 0);
        chk("st0_data", last_we_data, 32'h2C);
        chk("st0_rdata", rd, 0);
        do_req(1'b0, 32'h1001_0000, 32'h0, rd, er, lat);
        chk("ld0_data", rd, 32'h2C);

        do_req(1'b1, 32'h1001_000C, 32'hFF, rd, er, lat);
        chk("st3_addr", last_we_addr, 3);
        do_req(1'b0, 32'h1001_0100, 32'h0, rd, er, lat);
        chk("oob_err", er, 1);
        chk("oob_rdata", rd, 0);
        chk("oob_lat", lat, 1);

        wc0 = we_cnt;
        do_req(1'b0, 32'h1001_0002, 32'h0, rd, er, lat);
        chk("mis_err", er, 1);
        do_req(1'b1, 32'h0040_0004, 32'h1234, rd, er, lat);
        chk("romst_err", er, 1);
        chk("err_no_we", we_cnt - wc0, 0);

`ifdef MIPS_MEM_CTRL_GPIO_EN
        do_req(1'b1, TB_GPIO, 32'hA5, rd, er, lat);
        chk("gpio_st_err", er, 0);
        chk("gpio_val", gpio_out, 32'hA5);
        do_req(1'b0, TB_GPIO, 32'h0, rd, er, lat);
        chk("gpio_ld", rd, 32'hA5);
`else
        do_req(1'b1, TB_GPIO, 32'hA5, rd, er, lat);
        chk("gpio_unmapped", er, 1);
        chk("gpio_lat", lat, 1);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 7))
                0:       a = TB_TEXT + 4 * $urandom_range(0, DEPTH - 1);
                1, 2:    a = TB_DATA + 4 * $urandom_range(0, DEPTH - 1);
                3:       a = ($urandom_range(0, 1) == 1) ? TB_DATA + 4 * DEPTH : TB_TEXT - 4;
                4:       a = TB_DATA + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
                5:       a = TB_GPIO;
                6:       a = $urandom;
                default: a = ($urandom_range(0, 1) == 1) ? TB_DATA + 4 * (DEPTH - 1) : TB_TEXT + 4 * (DEPTH - 1);
            endcase
            do_req(1'($urandom_range(0, 1)), a, $urandom, rd, er, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the second ACCESS cycle of a 3-wait store
        w3 = 0;
        v3 = 0;
        r3_req_valid = 1'b1; r3_req_we = 1'b1; r3_req_addr = 32'h1001_0004; r3_req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        r3_req_valid = 1'b0;
        w3 += int'(r3_ram_we);
        v3 += int'(r3_rsp_valid);
        chk("r3_wr_addr", r3_ram_addr, 1);
        @(negedge clk);
        w3 += int'(r3_ram_we);
        v3 += int'(r3_rsp_valid);
        r3_reset = 1'b1;
        @(negedge clk);
        r3_reset = 1'b0;
        chk("r3_rst_ready", r3_req_ready, 1);
        chk("r3_rst_valid", r3_rsp_valid, 0);
        chk("r3_rst_we", r3_ram_we, 0);
        repeat (5) begin
            w3 += int'(r3_ram_we);
            v3 += int'(r3_rsp_valid);
            @(negedge clk);
        end
        chk("r3_we_pulses", w3, 1);
        chk("r3_no_rsp", v3, 0);
        chk("r3_mem", ram3_mem[1], 32'hDEAD_BEEF);

        r3_req_valid = 1'b1; r3_req_we = 1'b0; r3_req_addr = 32'h0040_0008;
        @(negedge clk);
        r3_req_valid = 1'b0;
        n = 1;
        while (!r3_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("r3_lat", n, 4);
        chk("r3_rdata", r3_rsp_rdata, rom_word(2));
        chk("r3_err", r3_rsp_err, 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
